// File: rtl/ws_tile_controller.sv
// ws_tile_controller
//
// Sequencer for the weight-stationary PE array. A job is a series of tiles.
// Each tile loads ARRAY_COLS weight words and then streams N input-activation
// vectors through the skewed array. The block produces the BRAM read/write
// strobes and addresses for that traffic. The PE array itself is instantiated
// elsewhere.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   start            job request, accepted only while idle
//   abort            synchronous abort, returns to idle without done
//   cfg_num_vectors  N, activation vectors per tile
//   cfg_num_tiles    T, tiles per job
//   cfg_weight_base  weight address of tile 0
//   cfg_iact_base    start address of every iact channel
//   cfg_psum_base    start address of every psum channel
//   busy             high whenever the controller is not idle
//   load_weight      weight BRAM read enable
//   weight_addr      weight BRAM address
//   pe_load_weight   load_weight delayed one cycle, drives the array
//   iact_rd_en       per-column iact read enable
//   iact_addr        per-column iact address, column j at [j*ADDR_W +: ADDR_W]
//   psum_wr_en       per-row psum write strobe
//   psum_addr        per-row psum address, packed like iact_addr
//   done             one-cycle pulse when a job completes

module ws_tile_controller #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [LEN_W-1:0]             cfg_num_vectors,
    input  logic [LEN_W-1:0]             cfg_num_tiles,
    input  logic [ADDR_W-1:0]            cfg_weight_base,
    input  logic [ADDR_W-1:0]            cfg_iact_base,
    input  logic [ADDR_W-1:0]            cfg_psum_base,
    output logic                         busy,
    output logic                         load_weight,
    output logic [ADDR_W-1:0]            weight_addr,
    output logic                         pe_load_weight,
    output logic [ARRAY_COLS-1:0]        iact_rd_en,
    output logic [ARRAY_COLS*ADDR_W-1:0] iact_addr,
    output logic [ARRAY_ROWS-1:0]        psum_wr_en,
    output logic [ARRAY_ROWS*ADDR_W-1:0] psum_addr,
    output logic                         done
);

    // The compute counter must reach (2^LEN_W - 1) + ARRAY_ROWS + ARRAY_COLS.
    localparam int CNT_W = $clog2((1 << LEN_W) + ARRAY_ROWS + ARRAY_COLS);
    localparam int K_W   = (ARRAY_COLS > 1) ? $clog2(ARRAY_COLS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [K_W-1:0]    k_cnt;
    logic [CNT_W-1:0]  c_cnt;
    logic [LEN_W-1:0]  tile;
    logic [LEN_W-1:0]  num_vectors;
    logic [LEN_W-1:0]  num_tiles;
    logic [ADDR_W-1:0] iact_base;

    logic              cfg_zero;
    logic              k_last;
    logic              c_last;
    logic              more_tiles;
    logic [CNT_W-1:0]  c_total;

    assign cfg_zero   = (cfg_num_vectors == '0) || (cfg_num_tiles == '0);
    assign k_last     = (k_cnt == K_W'(ARRAY_COLS - 1));
    assign c_total    = CNT_W'(num_vectors) + CNT_W'(ARRAY_ROWS + ARRAY_COLS);
    assign c_last     = (c_cnt == c_total - CNT_W'(1));
    // One extra bit keeps tile+1 from wrapping when T is at its maximum.
    assign more_tiles = (({1'b0, tile} + (LEN_W+1)'(1)) < {1'b0, num_tiles});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = cfg_zero ? DONE : LOAD_W;
                end
            end
            LOAD_W: begin
                if (k_last) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                if (c_last) begin
                    next_state = more_tiles ? LOAD_W : DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // Output decode. Column j reads during compute cycles [j, j+N); row i
    // writes during [i+ARRAY_COLS+1, i+ARRAY_COLS+1+N), the extra cycle
    // covering the iact BRAM read latency.
    always_comb begin
        busy        = (state != IDLE);
        load_weight = (state == LOAD_W);
        done        = (state == DONE);
        iact_rd_en  = '0;
        psum_wr_en  = '0;
        if (state == COMPUTE) begin
            for (int j = 0; j < ARRAY_COLS; j++) begin
                iact_rd_en[j] = (c_cnt >= CNT_W'(j)) &&
                                (c_cnt < CNT_W'(j) + CNT_W'(num_vectors));
            end
            for (int i = 0; i < ARRAY_ROWS; i++) begin
                psum_wr_en[i] = (c_cnt >= CNT_W'(i + ARRAY_COLS + 1)) &&
                                (c_cnt < CNT_W'(i + ARRAY_COLS + 1) + CNT_W'(num_vectors));
            end
        end
    end

    // Delayed weight-load strobe for the array. Abort suppresses it so the
    // cycle after an abort never shows a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_load_weight <= 1'b0;
        end else begin
            pe_load_weight <= load_weight && !abort;
        end
    end

    // Counters, latched configuration and address generators. Everything
    // holds on abort. The weight address simply keeps counting across tiles,
    // giving weight_base + tile*ARRAY_COLS + k without a multiplier. The iact
    // addresses rewind to the base at each tile. The psum addresses run on
    // across the whole job, so each tile writes the next N locations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt       <= '0;
            c_cnt       <= '0;
            tile        <= '0;
            num_vectors <= '0;
            num_tiles   <= '0;
            iact_base   <= '0;
            weight_addr <= '0;
            iact_addr   <= '0;
            psum_addr   <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_vectors <= cfg_num_vectors;
                        num_tiles   <= cfg_num_tiles;
                        iact_base   <= cfg_iact_base;
                        tile        <= '0;
                        k_cnt       <= '0;
                        c_cnt       <= '0;
                        weight_addr <= cfg_weight_base;
                        iact_addr   <= {ARRAY_COLS{cfg_iact_base}};
                        psum_addr   <= {ARRAY_ROWS{cfg_psum_base}};
                    end
                end
                LOAD_W: begin
                    weight_addr <= weight_addr + ADDR_W'(1);
                    k_cnt       <= k_last ? '0 : k_cnt + K_W'(1);
                    c_cnt       <= '0;
                end
                COMPUTE: begin
                    c_cnt <= c_cnt + CNT_W'(1);
                    for (int j = 0; j < ARRAY_COLS; j++) begin
                        if (iact_rd_en[j]) begin
                            iact_addr[j*ADDR_W +: ADDR_W] <=
                                iact_addr[j*ADDR_W +: ADDR_W] + ADDR_W'(1);
                        end
                    end
                    for (int i = 0; i < ARRAY_ROWS; i++) begin
                        if (psum_wr_en[i]) begin
                            psum_addr[i*ADDR_W +: ADDR_W] <=
                                psum_addr[i*ADDR_W +: ADDR_W] + ADDR_W'(1);
                        end
                    end
                    // Iact strobes finish well before the last compute
                    // cycle, so the rewind never collides with an increment.
                    if (c_last && more_tiles) begin
                        tile      <= tile + LEN_W'(1);
                        k_cnt     <= '0;
                        iact_addr <= {ARRAY_COLS{iact_base}};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws_tile_controller.sv
// tb_ws_tile_controller
//
// Directed bench for ws_tile_controller in its 3x3 configuration. A
// reference model expands each job into the expected per-cycle outputs and
// queues them when the start request is driven. Each following cycle pops one
// entry and compares it against the DUT.

module tb_ws_tile_controller;

    localparam int R  = 3;
    localparam int C  = 3;
    localparam int AW = 32;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [LW-1:0]   cfg_num_vectors;
    logic [LW-1:0]   cfg_num_tiles;
    logic [AW-1:0]   cfg_weight_base;
    logic [AW-1:0]   cfg_iact_base;
    logic [AW-1:0]   cfg_psum_base;
    logic            busy;
    logic            load_weight;
    logic [AW-1:0]   weight_addr;
    logic            pe_load_weight;
    logic [C-1:0]    iact_rd_en;
    logic [C*AW-1:0] iact_addr;
    logic [R-1:0]    psum_wr_en;
    logic [R*AW-1:0] psum_addr;
    logic            done;

    ws_tile_controller #(
        .ARRAY_ROWS(R),
        .ARRAY_COLS(C),
        .ADDR_W(AW),
        .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .cfg_num_vectors(cfg_num_vectors),
        .cfg_num_tiles(cfg_num_tiles),
        .cfg_weight_base(cfg_weight_base),
        .cfg_iact_base(cfg_iact_base),
        .cfg_psum_base(cfg_psum_base),
        .busy(busy),
        .load_weight(load_weight),
        .weight_addr(weight_addr),
        .pe_load_weight(pe_load_weight),
        .iact_rd_en(iact_rd_en),
        .iact_addr(iact_addr),
        .psum_wr_en(psum_wr_en),
        .psum_addr(psum_addr),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            busy;
        logic            lw;
        logic [AW-1:0]   waddr;
        logic            plw;
        logic [C-1:0]    ien;
        logic [C*AW-1:0] iaddr;
        logic [R-1:0]    pen;
        logic [R*AW-1:0] paddr;
        logic            done;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected outputs for a whole job, one entry per cycle after the
    // start-accept edge, followed by one idle cycle.
    task automatic push_job(input int n, input int t, input logic [AW-1:0] wb,
                            input logic [AW-1:0] ib, input logic [AW-1:0] pb);
        exp_t e;
        int   cc;
        cc = n + R + C;
        if (n != 0 && t != 0) begin
            for (int tt = 0; tt < t; tt++) begin
                for (int k = 0; k < C; k++) begin
                    e       = '0;
                    e.busy  = 1'b1;
                    e.lw    = 1'b1;
                    e.waddr = wb + 32'(tt * C + k);
                    e.plw   = (k > 0);
                    sb.push_back(e);
                end
                for (int c = 0; c < cc; c++) begin
                    e      = '0;
                    e.busy = 1'b1;
                    e.plw  = (c == 0);
                    for (int j = 0; j < C; j++) begin
                        if (c >= j && c < j + n) begin
                            e.ien[j] = 1'b1;
                            e.iaddr[j*AW +: AW] = ib + 32'(c - j);
                        end
                    end
                    for (int i = 0; i < R; i++) begin
                        if (c >= i + C + 1 && c < i + C + 1 + n) begin
                            e.pen[i] = 1'b1;
                            e.paddr[i*AW +: AW] = pb + 32'(tt * n + c - i - C - 1);
                        end
                    end
                    sb.push_back(e);
                end
            end
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        sb.push_back(e);
        e = '0;
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e, input int cyc);
        chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
        chk($sformatf("load_weight@%0d", cyc), 32'(load_weight), 32'(e.lw));
        chk($sformatf("pe_load_weight@%0d", cyc), 32'(pe_load_weight), 32'(e.plw));
        chk($sformatf("iact_rd_en@%0d", cyc), 32'(iact_rd_en), 32'(e.ien));
        chk($sformatf("psum_wr_en@%0d", cyc), 32'(psum_wr_en), 32'(e.pen));
        chk($sformatf("done@%0d", cyc), 32'(done), 32'(e.done));
        if (e.lw) chk($sformatf("weight_addr@%0d", cyc), weight_addr, e.waddr);
        for (int j = 0; j < C; j++)
            if (e.ien[j]) chk($sformatf("iact_addr%0d@%0d", j, cyc),
                              iact_addr[j*AW +: AW], e.iaddr[j*AW +: AW]);
        for (int i = 0; i < R; i++)
            if (e.pen[i]) chk($sformatf("psum_addr%0d@%0d", i, cyc),
                              psum_addr[i*AW +: AW], e.paddr[i*AW +: AW]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".load_weight"}, 32'(load_weight), 32'd0);
        chk({tag, ".weight_addr"}, weight_addr, 32'd0);
        chk({tag, ".pe_load_weight"}, 32'(pe_load_weight), 32'd0);
        chk({tag, ".iact_rd_en"}, 32'(iact_rd_en), 32'd0);
        chk({tag, ".psum_wr_en"}, 32'(psum_wr_en), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        for (int j = 0; j < C; j++) chk({tag, ".iact_addr"}, iact_addr[j*AW +: AW], 32'd0);
        for (int i = 0; i < R; i++) chk({tag, ".psum_addr"}, psum_addr[i*AW +: AW], 32'd0);
    endtask

    // Called at a falling edge. Drives a start request and steps through the
    // queued expectations. A second start with different cfg can be injected
    // at cycle start2_at. An abort can be raised during cycle abort_at, which
    // cuts the expected job short and is followed by two idle cycles.
    task automatic apply_stimulus(input int n, input int t, input logic [AW-1:0] wb,
                                  input logic [AW-1:0] ib, input logic [AW-1:0] pb,
                                  input int start2_at, input int abort_at);
        exp_t idle_e;
        int   cyc;
        idle_e          = '0;
        cfg_num_vectors = LW'(n);
        cfg_num_tiles   = LW'(t);
        cfg_weight_base = wb;
        cfg_iact_base   = ib;
        cfg_psum_base   = pb;
        start           = 1'b1;
        abort           = 1'b0;
        push_job(n, t, wb, ib, pb);
        if (abort_at > 0) begin
            while (sb.size() > abort_at) void'(sb.pop_back());
            sb.push_back(idle_e);
            sb.push_back(idle_e);
        end
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            check_output(sb.pop_front(), cyc);
            if (cyc == start2_at) begin
                start           = 1'b1;
                cfg_num_vectors = 8'd7;
                cfg_num_tiles   = 8'd3;
                cfg_weight_base = 32'h0000_5000;
                cfg_iact_base   = 32'h0000_6000;
                cfg_psum_base   = 32'h0000_7000;
            end
            if (cyc == abort_at) abort = 1'b1;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        cfg_num_vectors = '0;
        cfg_num_tiles   = '0;
        cfg_weight_base = '0;
        cfg_iact_base   = '0;
        cfg_psum_base   = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3x3 job: N=3, T=1.
        apply_stimulus(3, 1, 32'h0, 32'h100, 32'h200, 0, 0);
        // Two tiles with a weight base offset.
        apply_stimulus(5, 2, 32'h10, 32'h40, 32'h300, 0, 0);
        // Empty jobs.
        apply_stimulus(0, 4, 32'h20, 32'h30, 32'h40, 0, 0);
        apply_stimulus(4, 0, 32'h20, 32'h30, 32'h40, 0, 0);
        // Start with different cfg during COMPUTE is ignored.
        apply_stimulus(3, 2, 32'h80, 32'h90, 32'hA0, 6, 0);
        // Abort at c=4 of tile 0, then a clean job.
        apply_stimulus(3, 1, 32'h0, 32'h100, 32'h200, 0, 8);
        apply_stimulus(3, 1, 32'h0, 32'h100, 32'h200, 0, 0);

        // Start and abort together in idle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        cfg_num_vectors = 8'd3;
        cfg_num_tiles   = 8'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort.busy", 32'(busy), 32'd0);
        chk("start_abort.load_weight", 32'(load_weight), 32'd0);

        // Maximum N with iact addresses wrapping past 2^32.
        apply_stimulus(255, 1, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FF80, 0, 0);

        // Asynchronous reset in the middle of LOAD_W.
        cfg_num_vectors = 8'd3;
        cfg_num_tiles   = 8'd1;
        cfg_weight_base = 32'h0;
        cfg_iact_base   = 32'h100;
        cfg_psum_base   = 32'h200;
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset.load_weight", 32'(load_weight), 32'd1);
        chk("pre_reset.weight_addr", weight_addr, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.busy", 32'(busy), 32'd0);
        apply_stimulus(3, 1, 32'h0, 32'h100, 32'h200, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
